// File: rtl/cpu_run_monitor_if.sv
// Program-load stream into the monitor and the instruction-memory write port it drives.
// master = program source / memory side, slave = cpu_run_monitor.
interface cpu_run_monitor_if #(
  parameter int XLEN = 32,
  parameter int AW   = 6
);
  logic            load_valid;
  logic            load_ready;
  logic [XLEN-1:0] load_data;
  logic            load_last;
  logic            imem_we;
  logic [AW-1:0]   imem_waddr;
  logic [XLEN-1:0] imem_wdata;

  modport master (
    output load_valid, load_data, load_last,
    input  load_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  load_valid, load_data, load_last,
    output load_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/cpu_run_monitor.sv
// Load/run controller for the RISC-V core: streams a program into imem (one word/cycle while load_ready),
// holds the core in reset, then runs until halt PC, stuck PC or timeout. RUN_MON_PC_TRACE_EN adds an 8-deep PC history.
module cpu_run_monitor #(
  parameter int XLEN         = 32,
  parameter int IMEM_DEPTH   = 64,
  parameter int TIMEOUT      = 1024,
  parameter int STUCK_CYCLES = 6,
  parameter int RST_CYCLES   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] halt_pc,
  input  logic [XLEN-1:0] pc,
  cpu_run_monitor_if.slave bus,
  output logic            cpu_reset,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [1:0]      halt_reason,
  output logic            load_ovf,
  output logic [31:0]     cycle_count,
  output logic [31:0]     retire_count
`ifdef RUN_MON_PC_TRACE_EN
  ,
  input  logic [2:0]      trace_idx,
  output logic [XLEN-1:0] trace_pc
`endif
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int SW = $clog2(STUCK_CYCLES);
  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [1:0] RSN_NONE  = 2'd0;
  localparam logic [1:0] RSN_HALT  = 2'd1;
  localparam logic [1:0] RSN_STUCK = 2'd2;
  localparam logic [1:0] RSN_TMO   = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  logic            start_ok, accept, changed, hold_end;
  logic [1:0]      term_code;
  logic [SW-1:0]   stuck_cnt, stuck_nxt;
  logic [HW-1:0]   hold_cnt;
  logic [AW-1:0]   waddr;
  logic            full;
  logic            first_run;
  logic [XLEN-1:0] prev_pc, halt_q;

  always_comb begin
    start_ok  = ((state == S_IDLE) || (state == S_DONE)) && start;
    accept    = (state == S_LOAD) && bus.load_valid;
    changed   = first_run || (pc != prev_pc);
    stuck_nxt = changed ? '0 : stuck_cnt + 1'b1;
    hold_end  = (hold_cnt == HW'(RST_CYCLES - 1));
    term_code = RSN_NONE;
    if (pc == halt_q)
      term_code = RSN_HALT;
    else if (stuck_nxt == SW'(STUCK_CYCLES - 1))
      term_code = RSN_STUCK;
    else if (cycle_count == 32'(TIMEOUT - 1))
      term_code = RSN_TMO;
  end

  // Words beyond the memory depth are still consumed so the source never stalls.
  assign bus.imem_we    = accept && !full;
  assign bus.imem_waddr = waddr;
  assign bus.imem_wdata = bus.load_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    cpu_reset      = 1'b1;
    busy           = 1'b0;
    done           = 1'b0;
    bus.load_ready = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        busy           = 1'b1;
        bus.load_ready = 1'b1;
        if (accept && bus.load_last) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        busy = 1'b1;
        if (hold_end) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        cpu_reset = 1'b0;
        if (term_code != RSN_NONE) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halt_q       <= '0;
      prev_pc      <= '0;
      first_run    <= 1'b0;
      waddr        <= '0;
      full         <= 1'b0;
      load_ovf     <= 1'b0;
      hold_cnt     <= '0;
      stuck_cnt    <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
      halt_reason  <= RSN_NONE;
      pass         <= 1'b0;
    end else begin
      if (start_ok) begin
        halt_q       <= halt_pc;
        first_run    <= 1'b1;
        waddr        <= '0;
        full         <= 1'b0;
        load_ovf     <= 1'b0;
        hold_cnt     <= '0;
        stuck_cnt    <= '0;
        cycle_count  <= '0;
        retire_count <= '0;
        halt_reason  <= RSN_NONE;
        pass         <= 1'b0;
      end
      // Address parks on the last word instead of wrapping; `full` marks it written.
      if (accept) begin
        if (full)
          load_ovf <= 1'b1;
        else if (waddr == AW'(IMEM_DEPTH - 1))
          full <= 1'b1;
        else
          waddr <= waddr + 1'b1;
      end
      if (state == S_HOLD) hold_cnt <= hold_cnt + 1'b1;
      if (state == S_RUN) begin
        first_run <= 1'b0;
        prev_pc   <= pc;
        stuck_cnt <= stuck_nxt;
        if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 1'b1;
        if (changed && (retire_count != 32'hFFFF_FFFF)) retire_count <= retire_count + 1'b1;
        if (term_code != RSN_NONE) begin
          halt_reason <= term_code;
          pass        <= (term_code == RSN_HALT);
        end
      end
    end
  end

`ifdef RUN_MON_PC_TRACE_EN
  logic [XLEN-1:0] trace_mem [8];
  logic [2:0]      trace_wp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_wp <= '0;
      for (int i = 0; i < 8; i++) trace_mem[i] <= '0;
    end else if (start_ok) begin
      trace_wp <= '0;
      for (int i = 0; i < 8; i++) trace_mem[i] <= '0;
    end else if (state == S_RUN) begin
      trace_mem[trace_wp] <= pc;
      trace_wp            <= trace_wp + 1'b1;
    end
  end

  // Entry written most recently sits one behind the write pointer.
  assign trace_pc = trace_mem[trace_wp - 3'd1 - trace_idx];
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized self-checking bench for cpu_run_monitor against a windowed reference model
// of load, hold and termination behaviour.
module tb_cpu_run_monitor;
  localparam int XLEN    = 32;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 64;
  localparam int STUCK   = 6;
  localparam int RSTC    = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [XLEN-1:0] halt_pc;
  logic [XLEN-1:0] pc;
  logic            cpu_reset, busy, done, pass, load_ovf;
  logic [1:0]      halt_reason;
  logic [31:0]     cycle_count, retire_count;

  cpu_run_monitor_if #(.XLEN(XLEN), .AW(AW)) bus ();

  cpu_run_monitor #(
    .XLEN(XLEN), .IMEM_DEPTH(DEPTH), .TIMEOUT(TIMEOUT),
    .STUCK_CYCLES(STUCK), .RST_CYCLES(RSTC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt_pc(halt_pc), .pc(pc),
    .bus(bus), .cpu_reset(cpu_reset), .busy(busy), .done(done), .pass(pass),
    .halt_reason(halt_reason), .load_ovf(load_ovf),
    .cycle_count(cycle_count), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0]   pc_seq [TIMEOUT];
  logic [31:0]   data_w [32];
  logic [31:0]   halt_v;
  logic [AW-1:0] wr_a [$];
  logic [31:0]   wr_d [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: scan the PC trace sample by sample; stuck means the last STUCK samples are identical.
  task automatic model(output int ncyc, output int nret, output int why);
    ncyc = 0; nret = 0; why = 0;
    for (int k = 0; k < TIMEOUT; k++) begin
      bit same;
      same = (k >= STUCK - 1);
      for (int j = k - STUCK + 2; same && j <= k; j++)
        if (pc_seq[j] != pc_seq[j-1]) same = 1'b0;
      if (pc_seq[k] == halt_v)   why = 1;
      else if (same)             why = 2;
      else if (k == TIMEOUT - 1) why = 3;
      if (why != 0) begin
        ncyc = k + 1;
        nret = 1;
        for (int j = 1; j <= k; j++) if (pc_seq[j] != pc_seq[j-1]) nret++;
        return;
      end
    end
  endtask

  task automatic make_pcs(input int mode);
    logic [31:0] p;
    p = 32'h100;
    for (int k = 0; k < TIMEOUT; k++) begin
      case (mode)
        0: pc_seq[k] = 32'(4 * k);
        1: pc_seq[k] = (k <= 10) ? 32'(32'h18 + 4 * k) : 32'h40;
        2: pc_seq[k] = 32'(4 * (k % 3));
        default: begin
          pc_seq[k] = p;
          case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: p = p + 32'd4;
            6, 7:             p = p;
            default:          p = 32'h100 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
          endcase
        end
      endcase
    end
  endtask

  task automatic scenario(input int nwords, input int gap_at, input int gap_len,
                          input bit rnd_gaps, input int abort_at);
    int  idx, guard, gcnt, hold, ri, exp_n, e_cyc, e_ret, e_why;
    bit  rdy, v, fin;
    wr_a.delete();
    wr_d.delete();
    for (int i = 0; i < nwords; i++) data_w[i] = $urandom;
    start   = 1'b1;
    halt_pc = halt_v;
    @(negedge clk);
    start = 1'b0;
    check_val("ready_after_start", 32'(bus.load_ready), 32'd1);
    check_val("cleared_cycles", cycle_count, 32'd0);
    check_val("cleared_reason", 32'(halt_reason), 32'd0);

    idx = 0; guard = 0; gcnt = 0;
    while (idx < nwords && guard < 500) begin
      rdy = bus.load_ready;
      v   = 1'b1;
      if (idx == gap_at && gcnt < gap_len) begin
        v = 1'b0;
        gcnt++;
      end else if (rnd_gaps && ($urandom_range(0, 3) == 0)) begin
        v = 1'b0;
      end
      bus.load_valid = v;
      bus.load_data  = data_w[idx];
      bus.load_last  = (idx == nwords - 1);
      #1;
      if (bus.imem_we) begin
        wr_a.push_back(bus.imem_waddr);
        wr_d.push_back(bus.imem_wdata);
      end
      @(posedge clk);
      if (v && rdy) idx++;
      @(negedge clk);
      guard++;
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    if (idx < nwords) check_val("load_timeout", 32'(idx), 32'(nwords));

    hold = 0; ri = 0; fin = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        fin = 1'b1;
        break;
      end
      if (abort_at >= 0 && ri == abort_at) begin
        #2 reset = 1'b0;
        #1;
        check_val("arst_cpu_reset", 32'(cpu_reset), 32'd1);
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_cycles", cycle_count, 32'd0);
        check_val("arst_retire", retire_count, 32'd0);
        check_val("arst_ready", 32'(bus.load_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (cpu_reset) hold++;
      else begin
        pc = pc_seq[(ri < TIMEOUT) ? ri : TIMEOUT - 1];
        ri++;
      end
      @(negedge clk);
    end
    check_val("done_seen", 32'(fin), 32'd1);

    model(e_cyc, e_ret, e_why);
    exp_n = (nwords < DEPTH) ? nwords : DEPTH;
    check_val("hold_cycles", 32'(hold), 32'(RSTC));
    check_val("run_cycles_to_done", 32'(ri), 32'(e_cyc));
    check_val("cycle_count", cycle_count, 32'(e_cyc));
    check_val("retire_count", retire_count, 32'(e_ret));
    check_val("halt_reason", 32'(halt_reason), 32'(e_why));
    check_val("pass", 32'(pass), 32'(e_why == 1));
    check_val("load_ovf", 32'(load_ovf), 32'(nwords > DEPTH));
    check_val("done_cpu_reset", 32'(cpu_reset), 32'd1);
    check_val("done_busy", 32'(busy), 32'd0);
    check_val("wr_count", 32'(wr_a.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < wr_a.size(); i++) begin
      check_val("wr_addr", 32'(wr_a[i]), 32'(i));
      check_val("wr_data", wr_d[i], data_w[i]);
    end
  endtask

  initial begin
    reset          = 1'b0;
    start          = 1'b0;
    halt_pc        = '0;
    pc             = '0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check_val("rst_ready", 32'(bus.load_ready), 32'd0);
    check_val("rst_we", 32'(bus.imem_we), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_pass", 32'(pass), 32'd0);
    check_val("rst_reason", 32'(halt_reason), 32'd0);
    check_val("rst_ovf", 32'(load_ovf), 32'd0);
    check_val("rst_counts", cycle_count | retire_count, 32'd0);
    check_val("rst_waddr", 32'(bus.imem_waddr), 32'd0);
    reset = 1'b1;

    // halt reached at 0x3C after 16 linear PCs
    halt_v = 32'h3C; make_pcs(0);
    scenario(16, -1, 0, 1'b0, -1);
    // PC freezes at 0x40
    halt_v = 32'hFFFF_FFFC; make_pcs(1);
    scenario(5, -1, 0, 1'b0, -1);
    // tight loop never halts
    halt_v = 32'hFFFF_FFFC; make_pcs(2);
    scenario(3, -1, 0, 1'b0, -1);
    // overflow: more words than imem depth
    halt_v = 32'h20; make_pcs(0);
    scenario(DEPTH + 2, -1, 0, 1'b0, -1);
    // valid gap mid-load
    halt_v = 32'h10; make_pcs(0);
    scenario(8, 4, 3, 1'b0, -1);
    // async reset mid-run, then a clean reload
    halt_v = 32'hFFFF_FFFC; make_pcs(0);
    scenario(4, -1, 0, 1'b0, 5);
    halt_v = 32'h3C; make_pcs(0);
    scenario(16, -1, 0, 1'b0, -1);

    for (int r = 0; r < 12; r++) begin
      make_pcs(3);
      halt_v = ($urandom_range(0, 1) == 1) ? pc_seq[$urandom_range(0, TIMEOUT - 1)] : 32'hFFFF_FFFC;
      scenario($urandom_range(1, 20), -1, 0, 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
